// File: rtl/led_pwm_register_io.sv
// Multi-channel PWM LED peripheral behind a word-indexed register file.
// One prescaler and one period counter are shared; duty values are double-buffered into shadows.
module led_pwm_register_io #(
  parameter int DATA_WIDTH    = 32,
  parameter int CHANNELS      = 8,
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE_BITS = 16,
  localparam int ADDR_WIDTH   = $clog2(CHANNELS + 3) + 1
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic [ADDR_WIDTH-1:0] WADDR,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  WVALID,
  output logic                  WERROR,
  input  logic [ADDR_WIDTH-1:0] RADDR,
  output logic [DATA_WIDTH-1:0] RDATA,
  input  logic                  RVALID,
  output logic                  RERROR,
  output logic [CHANNELS-1:0]   led_gpio,
  output logic                  PERIOD_TICK
);

  localparam logic [ADDR_WIDTH-1:0] CTRL_IDX     = '0;
  localparam logic [ADDR_WIDTH-1:0] PRESCALE_IDX = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] STATUS_IDX   = ADDR_WIDTH'(CHANNELS + 2);
  localparam logic [PWM_BITS-1:0]   CNT_LAST     = PWM_BITS'((1 << PWM_BITS) - 2);

  logic                     en_reg;
  logic                     inv_reg;
  logic [PRESCALE_BITS-1:0] prescale_reg;
  logic [PRESCALE_BITS-1:0] pre_cnt_reg;
  logic [PWM_BITS-1:0]      pwm_cnt_reg;
  logic [PWM_BITS-1:0]      duty_reg   [CHANNELS];
  logic [PWM_BITS-1:0]      shadow_reg [CHANNELS];
  logic [DATA_WIDTH-1:0]    rdata_reg;
  logic [DATA_WIDTH-1:0]    rd_word;
  logic [CHANNELS-1:0]      led_reg;
  logic [CHANNELS-1:0]      led_next;
  logic [CHANNELS-1:0]      duty_wr;
  logic                     tick_reg;
  logic                     wr_ok;
  logic                     rd_ok;
  logic                     step;
  logic                     wrap;
  logic                     unused_wdata;

  assign WERROR = RESETn & WVALID & (WADDR >= STATUS_IDX);
  assign RERROR = RESETn & RVALID & (RADDR > STATUS_IDX);
  assign wr_ok  = WVALID & ~WERROR;
  assign rd_ok  = RVALID & ~RERROR;
  assign unused_wdata = ^WDATA;

  // >= rather than == so a PRESCALE lowered below the running count steps at once
  assign step = en_reg & (pre_cnt_reg >= prescale_reg);
  assign wrap = step & (pwm_cnt_reg == CNT_LAST);

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign duty_wr[gi]  = wr_ok & (WADDR == ADDR_WIDTH'(gi + 2));
      assign led_next[gi] = (en_reg & (pwm_cnt_reg < shadow_reg[gi])) ^ inv_reg;
    end
  endgenerate

  always_comb begin
    rd_word = '0;
    if (RADDR == CTRL_IDX) begin
      rd_word[1:0] = {inv_reg, en_reg};
    end else if (RADDR == PRESCALE_IDX) begin
      rd_word[PRESCALE_BITS-1:0] = prescale_reg;
    end else if (RADDR == STATUS_IDX) begin
      rd_word[PWM_BITS+CHANNELS-1:0] = {led_reg, pwm_cnt_reg};
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (RADDR == ADDR_WIDTH'(i + 2)) rd_word[PWM_BITS-1:0] = duty_reg[i];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      en_reg       <= 1'b0;
      inv_reg      <= 1'b0;
      prescale_reg <= '0;
      pre_cnt_reg  <= '0;
      pwm_cnt_reg  <= '0;
      rdata_reg    <= '0;
      led_reg      <= '0;
      tick_reg     <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_reg[i]   <= '0;
        shadow_reg[i] <= '0;
      end
    end else begin
      tick_reg <= 1'b0;
      if (!en_reg) begin
        pre_cnt_reg <= '0;
        pwm_cnt_reg <= '0;
      end else if (step) begin
        pre_cnt_reg <= '0;
        if (wrap) begin
          pwm_cnt_reg <= '0;
          tick_reg    <= 1'b1;
        end else begin
          pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
        end
      end else begin
        pre_cnt_reg <= pre_cnt_reg + 1'b1;
      end

      // shadows take the pre-write duty, so a write on the wrap edge lands next period
      for (int i = 0; i < CHANNELS; i++) begin
        if (!en_reg || wrap) shadow_reg[i] <= duty_reg[i];
        if (duty_wr[i]) duty_reg[i] <= WDATA[PWM_BITS-1:0];
      end

      if (wr_ok && WADDR == CTRL_IDX) {inv_reg, en_reg} <= WDATA[1:0];
      if (wr_ok && WADDR == PRESCALE_IDX) prescale_reg <= WDATA[PRESCALE_BITS-1:0];
      if (rd_ok) rdata_reg <= rd_word;
      led_reg <= led_next;
    end
  end

  assign RDATA       = rdata_reg;
  assign led_gpio    = led_reg;
  assign PERIOD_TICK = tick_reg;

endmodule

// File: tb/tb_led_pwm_register_io.sv
// Bench for led_pwm_register_io: per-cycle reference model plus directed register/PWM scenarios.
module tb_led_pwm_register_io;

  localparam int CH = 8;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NSTEPS = 255;

  logic          CLK = 1'b0;
  logic          RESETn;
  logic [AW-1:0] WADDR;
  logic [DW-1:0] WDATA;
  logic          WVALID;
  logic          WERROR;
  logic [AW-1:0] RADDR;
  logic [DW-1:0] RDATA;
  logic          RVALID;
  logic          RERROR;
  logic [CH-1:0] led_gpio;
  logic          PERIOD_TICK;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  always #5 CLK = ~CLK;

  led_pwm_register_io dut (
    .CLK(CLK), .RESETn(RESETn),
    .WADDR(WADDR), .WDATA(WDATA), .WVALID(WVALID), .WERROR(WERROR),
    .RADDR(RADDR), .RDATA(RDATA), .RVALID(RVALID), .RERROR(RERROR),
    .led_gpio(led_gpio), .PERIOD_TICK(PERIOD_TICK)
  );

  // Reference model state
  bit          m_en, m_inv, m_tick;
  int          m_ps, m_pre, m_cnt;
  int          m_duty [CH];
  int          m_shadow [CH];
  logic [CH-1:0] m_led;
  logic [DW-1:0] m_rdata;

  function automatic logic [DW-1:0] m_read(int idx);
    logic [DW-1:0] v;
    v = '0;
    if (idx == 0)          v[1:0] = {m_inv, m_en};
    else if (idx == 1)     v = DW'(m_ps);
    else if (idx <= CH+1)  v = DW'(m_duty[idx-2]);
    else                   v = {16'h0, m_led, 8'(m_cnt)};
    return v;
  endfunction

  always @(posedge CLK) begin : model
    logic [CH-1:0] nl;
    int  wa, ra;
    bit  st, wrp;
    if (!RESETn) begin
      m_en = 0; m_inv = 0; m_ps = 0; m_pre = 0; m_cnt = 0; m_tick = 0;
      m_led = '0; m_rdata = '0;
      for (int i = 0; i < CH; i++) begin m_duty[i] = 0; m_shadow[i] = 0; end
      chk_on = 1'b1;
    end else begin
      wa = int'(WADDR);
      ra = int'(RADDR);
      for (int i = 0; i < CH; i++) nl[i] = (m_en && (m_cnt < m_shadow[i])) ^ m_inv;
      if (RVALID && ra <= CH+2) m_rdata = m_read(ra);
      st  = m_en && (m_pre >= m_ps);
      wrp = st && (m_cnt == NSTEPS-1);
      m_tick = wrp;
      if (!m_en) begin
        m_pre = 0; m_cnt = 0;
        for (int i = 0; i < CH; i++) m_shadow[i] = m_duty[i];
      end else if (st) begin
        m_pre = 0;
        m_cnt = (m_cnt + 1) % NSTEPS;
        if (wrp) for (int i = 0; i < CH; i++) m_shadow[i] = m_duty[i];
      end else begin
        m_pre = m_pre + 1;
      end
      if (WVALID && wa <= CH+1) begin
        if (wa == 0)      begin m_en = WDATA[0]; m_inv = WDATA[1]; end
        else if (wa == 1) m_ps = int'(WDATA[15:0]);
        else              m_duty[wa-2] = int'(WDATA[7:0]);
      end
      m_led = nl;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge CLK) begin
    logic ew, er;
    if (chk_on) begin
      ew = RESETn && WVALID && (int'(WADDR) >= CH+2);
      er = RESETn && RVALID && (int'(RADDR) > CH+2);
      total++;
      if (led_gpio !== m_led || PERIOD_TICK !== m_tick || RDATA !== m_rdata ||
          WERROR !== ew || RERROR !== er) begin
        bad++;
        $display("FAIL model t=%0t led=%h/%h tick=%b/%b rdata=%h/%h werr=%b/%b rerr=%b/%b (got/expected)",
                 $time, led_gpio, m_led, PERIOD_TICK, m_tick, RDATA, m_rdata, WERROR, ew, RERROR, er);
      end
    end
  end

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic wr(int a, logic [DW-1:0] d, output logic err);
    WADDR = AW'(a); WDATA = d; WVALID = 1'b1;
    #1 err = WERROR;
    @(posedge CLK); #1;
    WVALID = 1'b0;
    $display("wr idx=%0d data=%h werror=%0b", a, d, err);
  endtask

  task automatic rd(int a, output logic [DW-1:0] q, output logic err);
    RADDR = AW'(a); RVALID = 1'b1;
    #1 err = RERROR;
    @(posedge CLK); #1;
    RVALID = 1'b0;
    q = RDATA;
    $display("rd idx=%0d rdata=%h rerror=%0b", a, q, err);
  endtask

  task automatic wait_tick(int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (PERIOD_TICK) found = 1'b1;
      @(posedge CLK); #1;
      if (found) break;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL wait_tick: got no PERIOD_TICK within %0d cycles, expected one", budget);
    end
  endtask

  task automatic count_win(int n, int wr_at, int wa, logic [DW-1:0] wd,
                           output int h0, output int h1, output int h2, output int tk);
    h0 = 0; h1 = 0; h2 = 0; tk = 0;
    for (int i = 0; i < n; i++) begin
      if (i == wr_at) begin
        WADDR = AW'(wa); WDATA = wd; WVALID = 1'b1;
        $display("wr idx=%0d data=%h (in window)", wa, wd);
      end else begin
        WVALID = 1'b0;
      end
      @(negedge CLK);
      h0 += int'(led_gpio[0]);
      h1 += int'(led_gpio[1]);
      h2 += int'(led_gpio[2]);
      tk += int'(PERIOD_TICK);
      @(posedge CLK); #1;
    end
    WVALID = 1'b0;
    $display("window n=%0d led0=%0d led1=%0d led2=%0d ticks=%0d", n, h0, h1, h2, tk);
  endtask

  initial begin
    logic [DW-1:0] q;
    logic e;
    int h0, h1, h2, tk;

    // Reset with erroring strobes held high: errors must stay 0
    RESETn = 1'b0; WVALID = 1'b1; WADDR = AW'(10); WDATA = '1;
    RVALID = 1'b1; RADDR = AW'(12);
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_werror", DW'(WERROR), 0);
    chk("rst_rerror", DW'(RERROR), 0);
    chk("rst_led", DW'(led_gpio), 0);
    chk("rst_tick", DW'(PERIOD_TICK), 0);
    chk("rst_rdata", RDATA, 0);
    WVALID = 1'b0; RVALID = 1'b0;
    RESETn = 1'b1;
    idle(1);

    // 1: all indices read 0 after reset
    for (int a = 0; a <= 10; a++) begin
      rd(a, q, e);
      chk($sformatf("t1_rd%0d", a), q, 0);
      chk($sformatf("t1_rerr%0d", a), DW'(e), 0);
    end

    // 2: duty 64 / 255, prescale 0
    wr(1, 0, e); wr(2, 64, e); wr(3, 255, e); wr(0, 1, e);
    wait_tick(600);
    count_win(NSTEPS, -1, 0, 0, h0, h1, h2, tk);
    chk("t2_led0_high", DW'(h0), 64);
    chk("t2_led1_high", DW'(h1), 255);
    chk("t2_ticks", DW'(tk), 1);

    // 3: mid-period duty change applies from the next period
    count_win(NSTEPS, 30, 2, 10, h0, h1, h2, tk);
    chk("t3_cur_period", DW'(h0), 64);
    count_win(NSTEPS, -1, 0, 0, h0, h1, h2, tk);
    chk("t3_next_period", DW'(h0), 10);
    chk("t3_ticks", DW'(tk), 1);

    // 4: prescale 3 stretches each step to 4 clocks
    wr(1, 3, e); wr(4, 2, e);
    wait_tick(3000);
    count_win(4*NSTEPS, -1, 0, 0, h0, h1, h2, tk);
    chk("t4_led2_high", DW'(h2), 8);
    chk("t4_led0_high", DW'(h0), 40);
    chk("t4_led1_high", DW'(h1), 1020);
    chk("t4_ticks", DW'(tk), 1);

    // 5: errored accesses have no effect
    rd(0, q, e);
    chk("t5_ctrl", q, 1);
    wr(10, 32'hFFFF_FFFF, e);
    chk("t5_werr_status", DW'(e), 1);
    wr(11, 5, e);
    chk("t5_werr_11", DW'(e), 1);
    rd(12, q, e);
    chk("t5_rerr_12", DW'(e), 1);
    chk("t5_rdata_held", q, 1);
    rd(1, q, e);  chk("t5_prescale", q, 3);
    rd(2, q, e);  chk("t5_duty0", q, 10);
    rd(4, q, e);  chk("t5_duty2", q, 2);
    wr(9, 32'h1234_5678, e);
    rd(9, q, e);  chk("t5_duty7_trunc", q, 32'h78);
    // same-cycle read and write return the old value
    WADDR = AW'(3); WDATA = 7; WVALID = 1'b1;
    RADDR = AW'(3); RVALID = 1'b1;
    @(posedge CLK); #1;
    WVALID = 1'b0; RVALID = 1'b0;
    $display("wr+rd idx=3 data=7 rdata=%h", RDATA);
    chk("t5_rw_same", RDATA, 255);
    rd(3, q, e);  chk("t5_rw_after", q, 7);

    // 6: inversion, disable, and reset mid-period
    wr(0, 0, e); wr(2, 0, e); wr(0, 3, e);
    idle(3);
    chk("t6_led0_inv", DW'(led_gpio[0]), 1);
    wr(0, 2, e);
    idle(2);
    chk("t6_all_inv", DW'(led_gpio), 32'hFF);
    rd(10, q, e);
    chk("t6_status", q, 32'h0000_FF00);
    wr(0, 1, e);
    idle(40);
    RESETn = 1'b0;
    @(posedge CLK); #1;
    chk("t6_rst_led", DW'(led_gpio), 0);
    chk("t6_rst_tick", DW'(PERIOD_TICK), 0);
    chk("t6_rst_rdata", RDATA, 0);
    RESETn = 1'b1;
    idle(1);
    rd(0, q, e);  chk("t6_ctrl_after", q, 0);
    rd(3, q, e);  chk("t6_duty1_after", q, 0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
